// File: rtl/pkt_sched_pkg.sv
// Shared router types and constants: packet format, default port/node counts
// and the round-robin index helper used by the scheduler.
package pkt_sched_pkg;

  localparam int DEST_W        = 4;
  localparam int PAYLOAD_W     = 12;
  localparam int ROUTER_NPORTS = 4;
  localparam int ROUTER_NNODES = 6;

  typedef struct packed {
    logic [DEST_W-1:0]    destID;
    logic [PAYLOAD_W-1:0] payload;
  } pkt_t;

  // Position k of a circular search that starts at base, over n entries.
  function automatic int rr_index(input int base, input int k, input int n);
    return (base + k) % n;
  endfunction

endpackage

// File: rtl/pkt_sched_cooldown_ctr.sv
// Per-output cooldown timer: ready while the output may accept a grant.
module cooldown_ctr #(
  parameter int COOLDOWN = 5
) (
  input  logic clk,
  input  logic rst_b,
  input  logic ld,
  output logic ready
);

  localparam logic [3:0] CD = 4'(COOLDOWN);

  logic [3:0] cnt;

  // cnt counts cycles since the last grant, with the grant cycle itself as 0.
  // It therefore reads 1 in the cycle after a grant, so the output is ready
  // again exactly COOLDOWN cycles after the grant (every cycle when COOLDOWN=1).
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)          cnt <= CD;
    else if (ld)         cnt <= 4'd1;
    else if (cnt != CD)  cnt <= cnt + 4'd1;
  end

  assign ready = (cnt == CD);

endmodule

// File: rtl/pkt_sched.sv
// Output scheduler: routes each FIFO head to its output, arbitrates each
// output round-robin among requesting inputs, and discards unroutable heads.
module pkt_sched
  import pkt_sched_pkg::*;
#(
  parameter int NPORTS   = ROUTER_NPORTS,
  parameter int NNODES   = ROUTER_NNODES,
  parameter int COOLDOWN = 5,
  localparam int PW      = (NPORTS > 1) ? $clog2(NPORTS) : 1,
  // destID i -> output port ROUTE[i*PW +: PW]; default maps i to i mod 4
  parameter logic [NNODES*PW-1:0] ROUTE = 12'b01_00_11_10_01_00
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic [NPORTS-1:0] q_empty,
  input  pkt_t              top_q [NPORTS],
  output logic [NPORTS-1:0] re,
  output logic [NPORTS-1:0] en_send,
  output pkt_t              value_to_send [NPORTS],
  output logic [NPORTS-1:0] out_ready,
  output logic              drop,
  output logic [7:0]        drop_cnt
);

  logic [PW-1:0]     ptr    [NPORTS];
  logic [PW-1:0]     winner [NPORTS];
  logic [NPORTS-1:0] req    [NPORTS];   // req[o][i]: input i wants output o
  pkt_t              val_raw [NPORTS];
  logic [NPORTS-1:0] ready;
  logic [NPORTS-1:0] grant;
  logic [NPORTS-1:0] re_raw;
  logic [NPORTS-1:0] drop_vec;
  logic [3:0]        ndrop;
  logic [8:0]        drop_sum;

  for (genvar o = 0; o < NPORTS; o++) begin : g_cool
    cooldown_ctr #(.COOLDOWN(COOLDOWN)) u_cool (
      .clk   (clk),
      .rst_b (rst_b),
      .ld    (grant[o]),
      .ready (ready[o])
    );
  end

  // Request decode, drop detection and per-output rotated search from ptr.
  always_comb begin
    logic [PW-1:0] idx;
    logic          found;
    idx      = '0;
    found    = 1'b0;
    grant    = '0;
    re_raw   = '0;
    drop_vec = '0;
    ndrop    = '0;
    for (int o = 0; o < NPORTS; o++) begin
      req[o]     = '0;
      winner[o]  = '0;
      val_raw[o] = '0;
    end
    for (int i = 0; i < NPORTS; i++) begin
      if (!q_empty[i]) begin
        if (int'(top_q[i].destID) < NNODES) begin
          req[ROUTE[int'(top_q[i].destID)*PW +: PW]][i] = 1'b1;
        end else begin
          drop_vec[i] = 1'b1;
          ndrop       = ndrop + 4'd1;
        end
      end
    end
    re_raw = drop_vec;
    for (int o = 0; o < NPORTS; o++) begin
      found = 1'b0;
      for (int k = 0; k < NPORTS; k++) begin
        idx = PW'(rr_index(int'(ptr[o]), k, NPORTS));
        if (ready[o] && !found && req[o][idx]) begin
          found     = 1'b1;
          winner[o] = idx;
        end
      end
      grant[o] = found;
      if (found) begin
        re_raw[winner[o]] = 1'b1;
        val_raw[o]        = top_q[winner[o]];
      end
    end
  end

  // Strobes are held low for the whole time reset is asserted.
  always_comb begin
    re        = rst_b ? re_raw : '0;
    en_send   = rst_b ? grant : '0;
    drop      = rst_b & (|drop_vec);
    out_ready = ready;
    for (int o = 0; o < NPORTS; o++) begin
      value_to_send[o] = (rst_b && grant[o]) ? val_raw[o] : '0;
    end
  end

  // Round-robin pointers advance past the winner on each grant.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int o = 0; o < NPORTS; o++) ptr[o] <= '0;
    end else begin
      for (int o = 0; o < NPORTS; o++) begin
        if (grant[o]) ptr[o] <= PW'(rr_index(int'(winner[o]), 1, NPORTS));
      end
    end
  end

  assign drop_sum = {1'b0, drop_cnt} + 9'(ndrop);

  // Saturating count of discarded heads.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) drop_cnt <= '0;
    else        drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

endmodule

// File: tb/tb_pkt_sched.sv
// Bench for pkt_sched: reset-state vector table, hand-written cooldown /
// saturation / mid-cooldown-reset sequences, and a randomized run against a
// timestamp-based reference model.
module tb_pkt_sched;
  import pkt_sched_pkg::*;

  localparam int NP = 4;
  localparam int NN = 6;
  localparam int CD = 5;

  logic          clk = 1'b0;
  logic          rst_b = 1'b0;
  logic [NP-1:0] q_empty = '1;
  pkt_t          top_q [NP];
  logic [NP-1:0] re, en_send, out_ready;
  pkt_t          value_to_send [NP];
  logic          drop;
  logic [7:0]    drop_cnt;

  int checks = 0;
  int errors = 0;

  pkt_sched #(.NPORTS(NP), .NNODES(NN), .COOLDOWN(CD)) dut (
    .clk           (clk),
    .rst_b         (rst_b),
    .q_empty       (q_empty),
    .top_q         (top_q),
    .re            (re),
    .en_send       (en_send),
    .value_to_send (value_to_send),
    .out_ready     (out_ready),
    .drop          (drop),
    .drop_cnt      (drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Reference model: each output remembers the cycle of its last grant and
  // the input after its last winner; drops are a plain saturating tally.
  int m_ptr  [NP];
  int m_last [NP];
  int m_win  [NP];
  int m_now;
  int m_drop_cnt;
  int m_ndrop;
  logic [NP-1:0] e_re, e_en, e_ready;
  logic          e_drop;
  pkt_t          e_val [NP];

  function automatic int route_of(input int d);
    return d % NP;
  endfunction

  task automatic model_reset();
    for (int o = 0; o < NP; o++) begin
      m_ptr[o]  = 0;
      m_last[o] = -1000;
    end
    m_now = 0;
    m_drop_cnt = 0;
  endtask

  task automatic model_eval();
    e_re = '0; e_en = '0; e_drop = 1'b0; m_ndrop = 0;
    for (int o = 0; o < NP; o++) begin
      e_val[o]   = '0;
      m_win[o]   = -1;
      e_ready[o] = (m_now - m_last[o]) >= CD;
      if (e_ready[o]) begin
        for (int k = 0; k < NP; k++) begin
          int i;
          i = (m_ptr[o] + k) % NP;
          if (!q_empty[i] && int'(top_q[i].destID) < NN &&
              route_of(int'(top_q[i].destID)) == o) begin
            m_win[o] = i;
            break;
          end
        end
      end
      if (m_win[o] >= 0) begin
        e_en[o] = 1'b1;
        e_re[m_win[o]] = 1'b1;
        e_val[o] = top_q[m_win[o]];
      end
    end
    for (int i = 0; i < NP; i++) begin
      if (!q_empty[i] && int'(top_q[i].destID) >= NN) begin
        e_re[i] = 1'b1;
        e_drop  = 1'b1;
        m_ndrop++;
      end
    end
  endtask

  task automatic model_commit();
    for (int o = 0; o < NP; o++) begin
      if (m_win[o] >= 0) begin
        m_last[o] = m_now;
        m_ptr[o]  = (m_win[o] + 1) % NP;
      end
    end
    m_drop_cnt = (m_drop_cnt + m_ndrop > 255) ? 255 : m_drop_cnt + m_ndrop;
    m_now++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // One model-checked cycle: compare at the falling edge, advance on the rising edge.
  task automatic cycle(input string tag);
    @(negedge clk);
    model_eval();
    chk({tag, ".re"}, 32'(re), 32'(e_re));
    chk({tag, ".en_send"}, 32'(en_send), 32'(e_en));
    chk({tag, ".drop"}, 32'(drop), 32'(e_drop));
    chk({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(m_drop_cnt));
    chk({tag, ".out_ready"}, 32'(out_ready), 32'(e_ready));
    for (int o = 0; o < NP; o++)
      chk({tag, ".value"}, 32'(value_to_send[o]), 32'(e_val[o]));
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    rst_b = 1'b1;
  endtask

  task automatic set_heads(input logic [NP-1:0] qe, input int d0, input int d1,
                           input int d2, input int d3);
    q_empty = qe;
    top_q[0] = '{destID: DEST_W'(d0), payload: PAYLOAD_W'($urandom)};
    top_q[1] = '{destID: DEST_W'(d1), payload: PAYLOAD_W'($urandom)};
    top_q[2] = '{destID: DEST_W'(d2), payload: PAYLOAD_W'($urandom)};
    top_q[3] = '{destID: DEST_W'(d3), payload: PAYLOAD_W'($urandom)};
  endtask

  typedef struct {
    logic [NP-1:0] qe;
    int            d [NP];
    logic [NP-1:0] ere;
    logic [NP-1:0] een;
    logic          edrop;
  } vec_t;

  vec_t vecs [8];
  int   order [4];

  initial begin
    for (int i = 0; i < NP; i++) top_q[i] = '0;

    // First cycle after reset: all outputs ready, every pointer at 0.
    vecs[0] = '{qe: 4'b1111, d: '{0, 0, 0, 0}, ere: 4'b0000, een: 4'b0000, edrop: 1'b0};
    vecs[1] = '{qe: 4'b1110, d: '{2, 0, 0, 0}, ere: 4'b0001, een: 4'b0100, edrop: 1'b0};
    vecs[2] = '{qe: 4'b1100, d: '{0, 1, 0, 0}, ere: 4'b0011, een: 4'b0011, edrop: 1'b0};
    vecs[3] = '{qe: 4'b0100, d: '{1, 1, 0, 1}, ere: 4'b0001, een: 4'b0010, edrop: 1'b0};
    vecs[4] = '{qe: 4'b1011, d: '{0, 0, 6, 0}, ere: 4'b0100, een: 4'b0000, edrop: 1'b1};
    vecs[5] = '{qe: 4'b0000, d: '{3, 7, 5, 4}, ere: 4'b1111, een: 4'b1011, edrop: 1'b1};
    vecs[6] = '{qe: 4'b1001, d: '{0, 2, 2, 0}, ere: 4'b0010, een: 4'b0100, edrop: 1'b0};
    vecs[7] = '{qe: 4'b0011, d: '{0, 0, 1, 5}, ere: 4'b0100, een: 4'b0010, edrop: 1'b0};

    for (int v = 0; v < 8; v++) begin
      do_reset();
      set_heads(vecs[v].qe, vecs[v].d[0], vecs[v].d[1], vecs[v].d[2], vecs[v].d[3]);
      @(negedge clk);
      chk($sformatf("vec%0d.re", v), 32'(re), 32'(vecs[v].ere));
      chk($sformatf("vec%0d.en_send", v), 32'(en_send), 32'(vecs[v].een));
      chk($sformatf("vec%0d.drop", v), 32'(drop), 32'(vecs[v].edrop));
      chk($sformatf("vec%0d.out_ready", v), 32'(out_ready), 32'hF);
      chk($sformatf("vec%0d.drop_cnt", v), 32'(drop_cnt), 32'h0);
    end

    // Inputs 0,1,3 contend for output 1 with persistent heads.
    order = '{0, 1, 3, 0};
    do_reset();
    set_heads(4'b0100, 1, 1, 0, 1);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk($sformatf("rr.en_send.c%0d", k), 32'(en_send),
          (k % 5 == 0) ? 32'h2 : 32'h0);
      chk($sformatf("rr.re.c%0d", k), 32'(re),
          (k % 5 == 0) ? 32'(1 << order[k / 5]) : 32'h0);
      if (k % 5 == 0)
        chk($sformatf("rr.value.c%0d", k), 32'(value_to_send[1]),
            32'(top_q[order[k / 5]]));
      @(posedge clk);
      #1;
    end

    // Persistent unroutable head: drop every cycle, counter saturates.
    do_reset();
    set_heads(4'b1110, 6, 0, 0, 0);
    @(negedge clk);
    chk("sat.first_re", 32'(re), 32'h1);
    chk("sat.first_drop", 32'(drop), 32'h1);
    chk("sat.first_en", 32'(en_send), 32'h0);
    for (int k = 0; k < 300; k++) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("sat.drop_cnt", 32'(drop_cnt), 32'd255);

    // Reset two cycles into a cooldown on output 0.
    do_reset();
    set_heads(4'b1101, 0, 4, 0, 0);
    @(negedge clk);
    chk("midrst.grant_en", 32'(en_send), 32'h1);
    chk("midrst.grant_re", 32'(re), 32'h2);
    @(posedge clk); #1;
    q_empty = '1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst.cooling", 32'(out_ready[0]), 32'h0);
    rst_b = 1'b0;
    set_heads(4'b0101, 0, 0, 0, 0);
    #1;
    chk("midrst.re_in_reset", 32'(re), 32'h0);
    chk("midrst.en_in_reset", 32'(en_send), 32'h0);
    @(posedge clk); #1;
    rst_b = 1'b1;
    model_reset();
    @(negedge clk);
    chk("midrst.ready_after", 32'(out_ready[0]), 32'h1);
    chk("midrst.ptr_winner_re", 32'(re), 32'h2);
    chk("midrst.ptr_winner_en", 32'(en_send), 32'h1);

    // Randomized traffic against the reference model.
    do_reset();
    set_heads('1, 0, 0, 0, 0);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NP; i++) begin
        if ($urandom_range(0, 1) == 0) begin
          q_empty[i] = ($urandom_range(0, 3) == 0);
          top_q[i] = '{destID: DEST_W'($urandom_range(0, 7)), payload: PAYLOAD_W'($urandom)};
        end
      end
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
